// File: rtl/block_slider_pkg.sv
// Shared definitions for the stacker game: grid geometry defaults, FSM state
// encoding and the cell-to-pixel conversion used by the slider datapath.
package block_slider_pkg;

    // Default grid geometry, shared with find_intersection and the draw logic
    localparam int DEF_CELL_W = 20;
    localparam int DEF_COLS   = 16;

    // Slider FSM state encoding
    localparam logic [2:0] ST_MOVE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_LAND  = 3'd2;
    localparam logic [2:0] ST_LOST  = 3'd3;
    localparam logic [2:0] ST_WON   = 3'd4;

    // Convert a cell count (0..31) into a 9-bit pixel coordinate
    function automatic logic [8:0] cells_to_px(input logic [4:0] cells, input logic [8:0] cell_w);
        logic [13:0] prod;
        prod = 14'(cells) * 14'(cell_w);
        return prod[8:0];
    endfunction

endpackage

// File: rtl/block_slider_move_tick_gen.sv
// Slide-rate divider: emits a one-cycle tick every DIV enabled cycles.
// A synchronous clear restarts the count so a new row always begins with a
// full step period.
module move_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;

    // Count enabled cycles and pulse tick when the count wraps
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_r <= CW'(0);
            tick  <= 1'b0;
        end else if (enable) begin
            if (cnt_r == LAST) begin
                cnt_r <= CW'(0);
                tick  <= 1'b1;
            end else begin
                cnt_r <= cnt_r + CW'(1);
                tick  <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/block_slider.sv
// Moving-block controller for the stacker game. Slides the current row's
// block, turns a stop key press into a one-cycle verdict sample point, trims
// the landed block to its overlap with the row below and ends in game-over
// or win. Internal state is in cells; pixel outputs are registered products.
module block_slider
    import block_slider_pkg::*;
#(
    parameter int CELL_W    = DEF_CELL_W,
    parameter int COLS      = DEF_COLS,
    parameter int INIT_SIZE = 5,
    parameter int NUM_ROWS  = 12,
    parameter int MOVE_DIV  = 2500000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       stop_req,
    input  logic       intersect_true,
    output logic       stop_true,
    output logic [8:0] curr_block_start,
    output logic [8:0] curr_block_end,
    output logic [3:0] curr_block_size,
    output logic [8:0] prev_block_start,
    output logic [8:0] prev_block_end,
    output logic [3:0] prev_block_size,
    output logic [3:0] row,
    output logic       draw_valid,
    output logic       game_over,
    output logic       game_won
);
    localparam logic [8:0] CW9 = 9'(CELL_W);

    logic [2:0] state_r, state_n;
    logic [3:0] col_r, col_n, size_r, size_n;
    logic [3:0] pcol_r, pcol_n, psize_r, psize_n, row_r, row_n;
    logic       dir_r, dir_n;          // 1 = moving right
    logic       stop_prev_r;
    logic       stop_edge_s, tick_s, clear_s, draw_n;
    logic [4:0] end_cell_s, pend_cell_s, ns_s, ne_s, ov_s;
    logic [8:0] curr_start_n, curr_end_n, prev_start_n, prev_end_n;

    assign stop_edge_s = stop_req & ~stop_prev_r;
    assign end_cell_s  = {1'b0, col_r} + {1'b0, size_r};
    assign pend_cell_s = {1'b0, pcol_r} + {1'b0, psize_r};

    move_tick_gen #(.DIV(MOVE_DIV)) u_tick (
        .clk    (clk),
        .reset  (resetn),
        .clear  (clear_s),
        .enable (state_r == ST_MOVE),
        .tick   (tick_s)
    );

    // Remember the previous stop key level for edge detection
    always_ff @(posedge clk) begin
        stop_prev_r <= stop_req;
    end

    // Overlap of the current block with the landed block below
    always_comb begin
        if (row_r == 4'd0) begin
            ns_s = {1'b0, col_r};
            ne_s = end_cell_s;
        end else begin
            ns_s = (col_r >= pcol_r) ? {1'b0, col_r} : {1'b0, pcol_r};
            ne_s = (end_cell_s <= pend_cell_s) ? end_cell_s : pend_cell_s;
        end
        if (ne_s > ns_s) begin
            ov_s = ne_s - ns_s;
        end else begin
            ov_s = 5'd0;
        end
    end

    // Next-state logic for the FSM and the cell-based datapath
    always_comb begin
        state_n = state_r;
        col_n   = col_r;
        dir_n   = dir_r;
        size_n  = size_r;
        pcol_n  = pcol_r;
        psize_n = psize_r;
        row_n   = row_r;
        draw_n  = 1'b0;
        clear_s = 1'b0;
        case (state_r)
            ST_MOVE: begin
                if (stop_edge_s) begin
                    state_n = ST_CHECK;
                end else if (tick_s && ({1'b0, size_r} != 5'(COLS))) begin
                    draw_n = 1'b1;
                    if (dir_r) begin
                        if (end_cell_s == 5'(COLS)) begin
                            dir_n = 1'b0;
                            col_n = col_r - 4'd1;
                        end else begin
                            col_n = col_r + 4'd1;
                        end
                    end else begin
                        if (col_r == 4'd0) begin
                            dir_n = 1'b1;
                            col_n = col_r + 4'd1;
                        end else begin
                            col_n = col_r - 4'd1;
                        end
                    end
                end else begin
                    state_n = ST_MOVE;
                end
            end
            ST_CHECK: begin
                if (intersect_true) begin
                    state_n = ST_LAND;
                end else begin
                    state_n = ST_LOST;
                end
            end
            ST_LAND: begin
                clear_s = 1'b1;
                // A zero overlap can only come from a bad verdict; treat it as a miss
                if (ov_s != 5'd0) begin
                    pcol_n  = ns_s[3:0];
                    psize_n = ov_s[3:0];
                    size_n  = ov_s[3:0];
                    col_n   = 4'd0;
                    dir_n   = 1'b1;
                    draw_n  = 1'b1;
                    if (row_r == 4'(NUM_ROWS - 1)) begin
                        state_n = ST_WON;
                    end else begin
                        row_n   = row_r + 4'd1;
                        state_n = ST_MOVE;
                    end
                end else begin
                    state_n = ST_LOST;
                end
            end
            ST_LOST: state_n = ST_LOST;
            ST_WON:  state_n = ST_WON;
            default: state_n = ST_LOST;
        endcase
    end

    // Pixel coordinates of the next datapath state
    always_comb begin
        curr_start_n = cells_to_px({1'b0, col_n}, CW9);
        curr_end_n   = cells_to_px({1'b0, col_n} + {1'b0, size_n}, CW9) - 9'd1;
        if (psize_n == 4'd0) begin
            prev_start_n = 9'd0;
            prev_end_n   = 9'd0;
        end else begin
            prev_start_n = cells_to_px({1'b0, pcol_n}, CW9);
            prev_end_n   = cells_to_px({1'b0, pcol_n} + {1'b0, psize_n}, CW9) - 9'd1;
        end
    end

    // State, datapath and registered outputs; reset overrides everything
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_r          <= ST_MOVE;
            col_r            <= 4'd0;
            dir_r            <= 1'b1;
            size_r           <= 4'(INIT_SIZE);
            pcol_r           <= 4'd0;
            psize_r          <= 4'd0;
            row_r            <= 4'd0;
            stop_true        <= 1'b0;
            draw_valid       <= 1'b1;
            game_over        <= 1'b0;
            game_won         <= 1'b0;
            curr_block_start <= 9'd0;
            curr_block_end   <= cells_to_px(5'(INIT_SIZE), CW9) - 9'd1;
            curr_block_size  <= 4'(INIT_SIZE);
            prev_block_start <= 9'd0;
            prev_block_end   <= 9'd0;
            prev_block_size  <= 4'd0;
            row              <= 4'd0;
        end else begin
            state_r          <= state_n;
            col_r            <= col_n;
            dir_r            <= dir_n;
            size_r           <= size_n;
            pcol_r           <= pcol_n;
            psize_r          <= psize_n;
            row_r            <= row_n;
            stop_true        <= (state_n == ST_CHECK);
            draw_valid       <= draw_n;
            game_over        <= (state_n == ST_LOST);
            game_won         <= (state_n == ST_WON);
            curr_block_start <= curr_start_n;
            curr_block_end   <= curr_end_n;
            curr_block_size  <= size_n;
            prev_block_start <= prev_start_n;
            prev_block_end   <= prev_end_n;
            prev_block_size  <= psize_n;
            row              <= row_n;
        end
    end

endmodule

// File: tb/tb_block_slider.sv
// Bench for block_slider: a game-level reference model predicts every draw
// event into a queue; a negedge monitor pops and compares whenever the DUT
// pulses draw_valid, and resolves each stop_true verdict from the rules.
module tb_block_slider;
    localparam int CW   = 20;
    localparam int NC   = 16;
    localparam int INIT = 5;
    localparam int NR   = 3;
    localparam int DIV  = 4;

    logic       clk = 1'b1;
    logic       resetn = 1'b0;
    logic       stop_req = 1'b0;
    logic       intersect_true;
    logic       stop_true, draw_valid, game_over, game_won;
    logic [8:0] curr_block_start, curr_block_end, prev_block_start, prev_block_end;
    logic [3:0] curr_block_size, prev_block_size, row;

    always #5 clk = ~clk;

    // find_intersection stand-in: left edge of the current block against the landed block
    assign intersect_true = (prev_block_size == 4'd0) ||
        ((curr_block_start >= prev_block_start) && (curr_block_start <= prev_block_end));

    block_slider #(.CELL_W(CW), .COLS(NC), .INIT_SIZE(INIT), .NUM_ROWS(NR), .MOVE_DIV(DIV)) dut (
        .clk(clk), .resetn(resetn), .stop_req(stop_req), .intersect_true(intersect_true),
        .stop_true(stop_true), .curr_block_start(curr_block_start), .curr_block_end(curr_block_end),
        .curr_block_size(curr_block_size), .prev_block_start(prev_block_start),
        .prev_block_end(prev_block_end), .prev_block_size(prev_block_size), .row(row),
        .draw_valid(draw_valid), .game_over(game_over), .game_won(game_won)
    );

    typedef struct {int col; int dir; int size; int pcol; int psize; int row; int kind;} exp_t;
    exp_t q[$];

    int  checks = 0, failures = 0, cyc = 0;
    int  m_col, m_dir, m_size, m_pcol, m_psize, m_row, over_at, last_step_cyc;
    bit  m_over, m_won, won_pending, armed = 1'b0, last_was_step;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Next bounce position of the block from the last presented one
    task automatic push_next_step();
        int c, d;
        if (m_size == NC) return;
        c = m_col; d = m_dir;
        if (d == 1 && c + m_size == NC) d = 0;
        else if (d == 0 && c == 0) d = 1;
        c = (d == 1) ? c + 1 : c - 1;
        q.push_back('{c, d, m_size, m_pcol, m_psize, m_row, 1});
    endtask

    task automatic compare_draw(input exp_t e);
        chk("curr_start", int'(curr_block_start), e.col * CW);
        chk("curr_end",   int'(curr_block_end), (e.col + e.size) * CW - 1);
        chk("curr_size",  int'(curr_block_size), e.size);
        chk("prev_start", int'(prev_block_start), (e.psize == 0) ? 0 : e.pcol * CW);
        chk("prev_end",   int'(prev_block_end), (e.psize == 0) ? 0 : (e.pcol + e.psize) * CW - 1);
        chk("prev_size",  int'(prev_block_size), e.psize);
        chk("row",        int'(row), e.row);
        chk("stop_true_during_draw", int'(stop_true), 0);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        int   ns, ne;
        bit   hit;
        cyc++;
        if (armed) begin
            if (draw_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_draw", int'(curr_block_start), -1);
                end else begin
                    e = q.pop_front();
                    compare_draw(e);
                    m_col = e.col; m_dir = e.dir;
                    if (e.kind == 1) begin
                        if (last_was_step) chk("step_interval", cyc - last_step_cyc, DIV);
                        last_was_step = 1'b1;
                        last_step_cyc = cyc;
                    end else begin
                        last_was_step = 1'b0;
                    end
                    if (e.kind == 2 && won_pending) m_won = 1'b1;
                    if (!m_won && !m_over) push_next_step();
                end
            end
            if (stop_true === 1'b1) begin
                chk("stop_while_ended", int'(m_over || m_won || over_at >= 0), 0);
                chk("verdict_curr_start", int'(curr_block_start), m_col * CW);
                chk("verdict_prev_size", int'(prev_block_size), m_psize);
                last_was_step = 1'b0;
                q.delete();
                hit = (m_psize == 0) || (m_col >= m_pcol && m_col < m_pcol + m_psize);
                if (hit) begin
                    if (m_psize == 0) begin
                        ns = m_col; ne = m_col + m_size;
                    end else begin
                        ns = (m_col > m_pcol) ? m_col : m_pcol;
                        ne = (m_col + m_size < m_pcol + m_psize) ? m_col + m_size : m_pcol + m_psize;
                    end
                    m_pcol = ns; m_psize = ne - ns; m_size = ne - ns;
                    if (m_row == NR - 1) won_pending = 1'b1;
                    else m_row++;
                    q.push_back('{0, 1, m_size, m_pcol, m_psize, m_row, 2});
                end else begin
                    over_at = cyc + 1;
                end
            end
            if (over_at >= 0 && cyc >= over_at) m_over = 1'b1;
            chk("game_over", int'(game_over), int'(m_over));
            chk("game_won", int'(game_won), int'(m_won));
        end
        #2;
        if (resetn) begin
            armed = 1'b1;
            q.delete();
            m_col = 0; m_dir = 1; m_size = INIT; m_pcol = 0; m_psize = 0; m_row = 0;
            m_over = 1'b0; m_won = 1'b0; won_pending = 1'b0; over_at = -1; last_was_step = 1'b0;
            q.push_back('{0, 1, INIT, 0, 0, 0, 0});
        end
    end

    task automatic do_reset();
        @(negedge clk); #1 resetn = 1'b1;
        @(negedge clk); #1 resetn = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Press the stop key while the block sits at cell c
    task automatic stop_at(input int c);
        int n = 0;
        @(negedge clk); #1;
        while (!(int'(curr_block_start) == c * CW && !stop_true) && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 500) chk("stop_at_timeout", int'(curr_block_start), c * CW);
        stop_req = 1'b1;
        idle(3);
        stop_req = 1'b0;
        idle(4);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Bounce through the right wall, then land, trim and win
        do_reset();
        idle(60);
        stop_at(3);
        stop_at(5);
        stop_at(5);
        repeat (3) begin stop_req = 1'b1; idle(2); stop_req = 1'b0; idle(3); end
        idle(10);

        // Missed landing from the left is game over; later stops ignored
        do_reset();
        stop_at(3);
        stop_at(1);
        repeat (3) begin stop_req = 1'b1; idle(2); stop_req = 1'b0; idle(3); end
        idle(20);

        // Stop edge coincident with a tick: stop wins, no step
        do_reset();
        begin
            int n = 0;
            @(negedge clk); #1;
            while (!(draw_valid && int'(curr_block_start) == 2 * CW) && n < 200) begin
                @(negedge clk); #1;
                n++;
            end
            if (n >= 200) chk("coinc_timeout", int'(curr_block_start), 2 * CW);
            repeat (3) @(negedge clk);
            #1 stop_req = 1'b1;
            @(negedge clk); #1;
            chk("coinc_stop_true", int'(stop_true), 1);
            chk("coinc_no_step", int'(draw_valid), 0);
            chk("coinc_curr_start", int'(curr_block_start), 2 * CW);
            idle(2);
            stop_req = 1'b0;
            idle(4);
        end

        // Reset asserted during CHECK returns to the reset state
        begin
            int n = 0;
            @(negedge clk); #1;
            while (int'(curr_block_start) != 4 * CW && n < 200) begin
                @(negedge clk); #1;
                n++;
            end
            stop_req = 1'b1;
            @(negedge clk); #1;
            chk("rst_check_stop_true", int'(stop_true), 1);
            resetn = 1'b1;
            @(negedge clk); #1;
            resetn = 1'b0;
            chk("rst_check_row", int'(row), 0);
            chk("rst_check_stop_clear", int'(stop_true), 0);
            stop_req = 1'b0;
            idle(10);
        end

        // Randomised games
        for (int g = 0; g < 6; g++) begin
            do_reset();
            for (int k = 0; k < 6; k++) begin
                idle($urandom_range(0, 60));
                if (game_over || game_won) break;
                stop_req = 1'b1;
                idle($urandom_range(1, 3));
                stop_req = 1'b0;
                idle(5);
            end
            idle(8);
        end

        idle(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
